// File: rtl/tb_axi4lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4lite_arbiter
//  Description : Round-robin arbiter that funnels NB_REQ simple command ports
//                onto a single AXI4-Lite master, one transaction at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  // Requester side
  input  logic [NB_REQ-1:0]               i_req_valid,
  output logic [NB_REQ-1:0]               o_req_ready,
  input  logic [NB_REQ-1:0]               i_req_wr,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0]    i_req_wdata,
  input  logic [NB_REQ*DATA_WIDTH/8-1:0]  i_req_strb,
  output logic [NB_REQ-1:0]               o_rsp_valid,
  output logic [DATA_WIDTH-1:0]           o_rsp_rdata,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_busy,
  output logic [$clog2(NB_REQ)-1:0]       o_grant_id,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0]           o_awaddr,
  output logic                            o_awvalid,
  input  logic                            i_awready,
  output logic [DATA_WIDTH-1:0]           o_wdata,
  output logic [DATA_WIDTH/8-1:0]         o_wstrb,
  output logic                            o_wvalid,
  input  logic                            i_wready,
  input  logic [1:0]                      i_bresp,
  input  logic                            i_bvalid,
  output logic                            o_bready,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0]           o_araddr,
  output logic                            o_arvalid,
  input  logic                            i_arready,
  input  logic [DATA_WIDTH-1:0]           i_rdata,
  input  logic [1:0]                      i_rresp,
  input  logic                            i_rvalid,
  output logic                            o_rready
);

  localparam int c_gw = $clog2(NB_REQ);
  localparam int c_cw = c_gw + 1;
  localparam int c_sw = DATA_WIDTH / 8;
  localparam logic [NB_REQ-1:0] c_one = {{(NB_REQ-1){1'b0}}, 1'b1};

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_write   = 3'd1;
  localparam logic [2:0] c_st_wr_resp = 3'd2;
  localparam logic [2:0] c_st_read    = 3'd3;
  localparam logic [2:0] c_st_rd_data = 3'd4;
  localparam logic [2:0] c_st_resp    = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [c_gw-1:0]       last_grant_q, last_grant_d;
  logic [c_gw-1:0]       grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [c_sw-1:0]       strb_q, strb_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

  logic                  w_arb_found;
  logic [c_gw-1:0]       w_arb_win;
  logic [c_cw-1:0]       w_arb_cand;
  logic [NB_REQ-1:0]     w_win_onehot;
  logic [NB_REQ-1:0]     w_owner_onehot;
  logic                  w_aw_done;
  logic                  w_w_done;

  logic [ADDR_WIDTH-1:0] w_req_addr  [NB_REQ];
  logic [DATA_WIDTH-1:0] w_req_wdata [NB_REQ];
  logic [c_sw-1:0]       w_req_strb  [NB_REQ];

  // Slice the flattened requester buses into per-requester views.
  genvar g;
  for (g = 0; g < NB_REQ; g++) begin : g_unpack
    assign w_req_addr[g]  = i_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_req_wdata[g] = i_req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_req_strb[g]  = i_req_strb[g*c_sw +: c_sw];
  end

  // A channel counts as done once its handshake happened, now or earlier.
  assign w_aw_done      = !aw_pend_q || i_awready;
  assign w_w_done       = !w_pend_q  || i_wready;
  assign w_win_onehot   = c_one << w_arb_win;
  assign w_owner_onehot = c_one << grant_id_q;

  // Round-robin search starting one past the last owner, wrapping at NB_REQ.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_win   = '0;
    w_arb_cand  = '0;
    for (int i = 1; i <= NB_REQ; i++) begin
      w_arb_cand = {1'b0, last_grant_q} + c_cw'(i);
      if (w_arb_cand >= c_cw'(NB_REQ)) begin
        w_arb_cand = w_arb_cand - c_cw'(NB_REQ);
      end
      if (!w_arb_found && i_req_valid[w_arb_cand[c_gw-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_win   = w_arb_cand[c_gw-1:0];
      end
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a single transaction walks its channel sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:    if (w_arb_found) state_d = i_req_wr[w_arb_win] ? c_st_write : c_st_read;
      c_st_write:   if (w_aw_done && w_w_done) state_d = c_st_wr_resp;
      c_st_wr_resp: if (i_bvalid) state_d = c_st_resp;
      c_st_read:    if (i_arready) state_d = c_st_rd_data;
      c_st_rd_data: if (i_rvalid) state_d = c_st_resp;
      c_st_resp:    state_d = c_st_idle;
      default:      state_d = c_st_idle;
    endcase
  end

  // Output decode; ready is masked during reset so it is low immediately.
  always_comb begin
    o_req_ready = '0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_rsp_valid = '0;
    o_busy      = 1'b1;
    case (state_q)
      c_st_idle: begin
        o_busy = 1'b0;
        if (w_arb_found && !rst) o_req_ready = w_win_onehot;
      end
      c_st_write: begin
        o_awvalid = aw_pend_q;
        o_wvalid  = w_pend_q;
      end
      c_st_wr_resp: o_bready    = 1'b1;
      c_st_read:    o_arvalid   = 1'b1;
      c_st_rd_data: o_rready    = 1'b1;
      c_st_resp:    o_rsp_valid = w_owner_onehot;
      default:      o_busy      = 1'b0;
    endcase
  end

  // Datapath next values: capture the winner's command and the slave's reply.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    case (state_q)
      c_st_idle: begin
        if (w_arb_found) begin
          last_grant_d = w_arb_win;
          grant_id_d   = w_arb_win;
          addr_d       = w_req_addr[w_arb_win];
          wdata_d      = w_req_wdata[w_arb_win];
          strb_d       = w_req_strb[w_arb_win];
          aw_pend_d    = i_req_wr[w_arb_win];
          w_pend_d     = i_req_wr[w_arb_win];
        end
      end
      c_st_write: begin
        if (i_awready) aw_pend_d = 1'b0;
        if (i_wready)  w_pend_d  = 1'b0;
      end
      c_st_wr_resp: begin
        if (i_bvalid) begin
          resp_d  = i_bresp;
          rdata_d = '0;
        end
      end
      c_st_rd_data: begin
        if (i_rvalid) begin
          rdata_d = i_rdata;
          resp_d  = i_rresp;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; last owner resets to NB_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= c_gw'(NB_REQ - 1);
      grant_id_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign o_grant_id  = grant_id_q;
  assign o_awaddr    = addr_q;
  assign o_araddr    = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = strb_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;

endmodule
`default_nettype wire
